// File: rtl/ls_unit.sv
// ls_unit: load/store stage. Issues data-memory accesses over a req/gnt/rvalid
// bus, stalls the pipeline until the access completes, and produces aligned,
// extended load data. Non-memory instructions pass straight through.
module ls_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_we_i,
    input  logic [DATA_W-1:0] rd_mem_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [EXE_W-1:0]  exe_info_bus_i,
    input  logic [5:0]        stall_i,
    output logic              stall_req_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              rd_we_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic [4:0]        rd_addr_o,
    output logic              misalign_o
);

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    logic              mem_re, mem_we, is_access, is_byte, is_half, is_word;
    logic              misalign, aligned_access;
    logic              req_c, stall_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c, load_ext_c;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              unused_bits;

    // Instruction decode; reserved size 11 behaves as a word.
    assign mem_re         = exe_info_bus_i[0];
    assign mem_we         = exe_info_bus_i[1];
    assign is_access      = mem_re | mem_we;
    assign is_byte        = (exe_info_bus_i[3:2] == 2'b00);
    assign is_half        = (exe_info_bus_i[3:2] == 2'b01);
    assign is_word        = ~is_byte & ~is_half;
    assign misalign       = is_access & ((is_half & mem_addr_i[0]) |
                                         (is_word & (|mem_addr_i[1:0])));
    assign aligned_access = is_access & ~misalign;
    assign unused_bits    = ^{stall_i, exe_info_bus_i};

    // Store lane placement: byte enables and replicated write data.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = rd_mem_data_i;
        if (is_byte) begin
            be_c    = BE_W'(4'b0001 << mem_addr_i[1:0]);
            wdata_c = {4{rd_mem_data_i[7:0]}};
        end else if (is_half) begin
            be_c    = BE_W'(4'b0011 << mem_addr_i[1:0]);
            wdata_c = {2{rd_mem_data_i[15:0]}};
        end
    end

    // Load lane extraction and extension using the captured access attributes.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = dmem_rdata_i[7:0];
            2'd1:    byte_sel = dmem_rdata_i[15:8];
            2'd2:    byte_sel = dmem_rdata_i[23:16];
            default: byte_sel = dmem_rdata_i[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_ext_c = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext_c = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext_c = dmem_rdata_i;
        endcase
    end

    // Next-state, bus request and stall request.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_access) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    lane_d  = mem_addr_i[1:0];
                    size_d  = exe_info_bus_i[3:2];
                    uns_d   = exe_info_bus_i[4];
                    state_d = dmem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                stall_c = 1'b1;
                if (dmem_rvalid_i) begin
                    data_d  = load_ext_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall_i[4]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    // Bus and stall outputs, forced quiet during reset.
    always_comb begin
        dmem_req_o   = req_c & ~rst;
        dmem_we_o    = req_c & ~rst & mem_we & ~mem_re;
        stall_req_o  = stall_c & ~rst;
        dmem_addr_o  = rst ? '0 : {mem_addr_i[ADDR_W-1:2], 2'b00};
        dmem_be_o    = rst ? '0 : be_c;
        dmem_wdata_o = rst ? '0 : wdata_c;
        misalign_o   = misalign & ~rst;
    end

    // Writeback outputs: pass-through, completed load, or suppressed store.
    always_comb begin
        rd_we_o    = 1'b0;
        rd_wdata_o = '0;
        rd_addr_o  = '0;
        if (!rst) begin
            rd_addr_o = rd_addr_i;
            if (!is_access) begin
                rd_we_o    = rd_we_i;
                rd_wdata_o = rd_mem_data_i;
            end else begin
                rd_wdata_o = data_q;
                if (mem_re && !misalign && state_q == DONE) rd_we_o = rd_we_i;
            end
        end
    end

endmodule
